// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller driving external tag/data storage.
// Optional feature macro: CACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module cache_ctrl #(
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 6,
  localparam int ADDR_W = TAG_W + INDEX_W + 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_ready,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic [INDEX_W-1:0] cs_index,
  output logic [2:0]         cs_word,
  output logic               cs_we_data,
  output logic               cs_we_tag,
  output logic [TAG_W-1:0]   cs_tag,
  output logic [DATA_W-1:0]  cs_data,
  input  logic [TAG_W-1:0]   cs_tag_in,
  input  logic               cs_valid_in,
  input  logic [DATA_W-1:0]  cs_data_in,
`ifdef CACHE_STATS_EN
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt,
`endif
  output logic [2:0]         dbg_state_o
);

  // Handshakes: cpu_req is sampled only in IDLE and cpu_ready is a one-cycle completion
  // pulse; mem_req/mem_we/mem_addr/mem_wdata hold stable until a cycle with mem_ack=1,
  // and mem_ack is ignored whenever mem_req=0.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    REFILL    = 3'd2,
    WRITE_MEM = 3'd3,
    RESP      = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          beat_q, beat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [TAG_W-1:0]    tag_l;
  logic [INDEX_W-1:0]  idx_l;
  logic [2:0]          word_l;
  logic                hit;

  assign tag_l  = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_l  = addr_q[3 +: INDEX_W];
  assign word_l = addr_q[2:0];
  assign hit    = cs_valid_in && (cs_tag_in == tag_l);

  assign cs_index    = idx_l;
  assign cs_tag      = tag_l;
  assign cpu_rdata   = rdata_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_ready  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cs_word    = word_l;
    cs_we_data = 1'b0;
    cs_we_tag  = 1'b0;
    cs_data    = wdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (we_q) begin
          cs_we_data = hit;
          state_d    = WRITE_MEM;
        end else if (hit) begin
          rdata_d = cs_data_in;
          state_d = RESP;
        end else begin
          beat_d  = 3'd0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag_l, idx_l, beat_q};
        cs_word  = beat_q;
        cs_data  = mem_rdata;
        if (mem_ack) begin
          cs_we_data = 1'b1;
          if (beat_q == word_l) rdata_d = mem_rdata;
          beat_d = beat_q + 3'd1;
          // The tag (and with it the valid bit) is written only with the last beat.
          if (beat_q == 3'd7) begin
            cs_we_tag = 1'b1;
            state_d   = RESP;
          end
        end
      end
      WRITE_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack) state_d = RESP;
      end
      RESP: begin
        cpu_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // An aborting reset must not commit a beat or validate a half-filled line.
    if (rst) begin
      cs_we_data = 1'b0;
      cs_we_tag  = 1'b0;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed scenarios plus randomized traffic checked against a
// line-level cache/memory model, with a tag/data storage array and a delayed-ack memory.
`timescale 1ns/1ps
module tb_cache_ctrl;
  localparam int DW  = 32;
  localparam int IW  = 5;
  localparam int TW  = 6;
  localparam int AW  = TW + IW + 3;
  localparam int TXW = 1 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_we, cpu_ready;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [IW-1:0] cs_index;
  logic [2:0]    cs_word;
  logic          cs_we_data, cs_we_tag;
  logic [TW-1:0] cs_tag, cs_tag_in;
  logic [DW-1:0] cs_data, cs_data_in;
  logic          cs_valid_in;
  logic [2:0]    dbg_state;
`ifdef CACHE_STATS_EN
  logic [15:0]   hit_cnt, miss_cnt;
`endif

  cache_ctrl #(.DATA_W(DW), .INDEX_W(IW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cs_index(cs_index), .cs_word(cs_word), .cs_we_data(cs_we_data), .cs_we_tag(cs_we_tag),
    .cs_tag(cs_tag), .cs_data(cs_data),
    .cs_tag_in(cs_tag_in), .cs_valid_in(cs_valid_in), .cs_data_in(cs_data_in),
`ifdef CACHE_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- external cache storage ----------------
  logic [TW-1:0] st_tag   [32];
  logic          st_valid [32];
  logic [DW-1:0] st_data  [32][8];
  logic          st_clear;

  always @(posedge clk) begin
    if (st_clear) begin
      for (int i = 0; i < 32; i++) st_valid[i] <= 1'b0;
    end else begin
      if (cs_we_data) st_data[cs_index][cs_word] <= cs_data;
      if (cs_we_tag) begin
        st_tag[cs_index]   <= cs_tag;
        st_valid[cs_index] <= 1'b1;
      end
    end
  end

  assign cs_tag_in   = st_tag[cs_index];
  assign cs_valid_in = st_valid[cs_index];
  assign cs_data_in  = st_data[cs_index][cs_word];

  // ---------------- event monitor ----------------
  int         data_wr_cnt = 0;
  int         tag_wr_cnt  = 0;
  int         ready_cnt   = 0;
  logic [2:0] tag_word    = '0;

  always @(posedge clk) begin
    if (cs_we_data) data_wr_cnt++;
    if (cs_we_tag) begin
      tag_wr_cnt++;
      tag_word = cs_word;
    end
    if (cpu_ready) ready_cnt++;
  end

  // ---------------- memory responder ----------------
  function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  logic [DW-1:0]  mem_wr [int];
  logic [TXW-1:0] act_q[$];
  int             ack_delay    = 0;
  int             wait_left    = 0;
  int             unstable_cnt = 0;
  logic           busy         = 1'b0;
  logic [AW-1:0]  hold_addr;
  logic           hold_we;

  always @(negedge clk) begin
    if (rst || !mem_req || mem_ack) begin
      mem_ack = 1'b0;
      busy    = 1'b0;
    end else begin
      if (!busy) begin
        busy      = 1'b1;
        hold_addr = mem_addr;
        hold_we   = mem_we;
        wait_left = ack_delay;
      end else if (mem_addr !== hold_addr || mem_we !== hold_we) begin
        unstable_cnt++;
      end
      if (wait_left == 0) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem_wr[int'(mem_addr)] = mem_wdata;
          act_q.push_back({1'b1, mem_addr, mem_wdata});
        end else begin
          mem_rdata = mem_wr.exists(int'(mem_addr)) ? mem_wr[int'(mem_addr)] : mem_init(mem_addr);
          act_q.push_back({1'b0, mem_addr, mem_rdata});
        end
      end else begin
        wait_left--;
      end
    end
  end

  // ---------------- reference model ----------------
  logic          ref_valid [32];
  logic [TW-1:0] ref_tag   [32];
  logic [DW-1:0] ref_data  [32][8];
  logic [DW-1:0] ref_mem_wr [int];
  logic [DW-1:0] last_rdata = '0;
  int            ref_hits   = 0;
  int            ref_misses = 0;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem_wr.exists(int'(a)) ? ref_mem_wr[int'(a)] : mem_init(a);
  endfunction

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cpu_access(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input int glitch_at);
    logic [TXW-1:0] exp_q[$];
    logic [IW-1:0]  idx;
    logic [TW-1:0]  tg;
    logic [2:0]     wd;
    logic [AW-1:0]  ba;
    logic [DW-1:0]  exp_rdata;
    logic           hit;
    int             exp_dw, exp_tw, base, d0, t0, r0, u0, n;
    tg  = addr[AW-1 -: TW];
    idx = addr[3 +: IW];
    wd  = addr[2:0];
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    exp_dw    = 0;
    exp_tw    = 0;
    exp_rdata = last_rdata;
    if (hit) ref_hits++; else ref_misses++;
    if (we) begin
      ref_mem_wr[int'(addr)] = wdata;
      exp_q.push_back({1'b1, addr, wdata});
      if (hit) begin
        ref_data[idx][wd] = wdata;
        exp_dw = 1;
      end
    end else if (hit) begin
      exp_rdata = ref_data[idx][wd];
    end else begin
      for (int b = 0; b < 8; b++) begin
        ba = {tg, idx, 3'(b)};
        ref_data[idx][b] = ref_read(ba);
        exp_q.push_back({1'b0, ba, ref_data[idx][b]});
      end
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
      exp_rdata      = ref_data[idx][wd];
      exp_dw         = 8;
      exp_tw         = 1;
    end
    last_rdata = exp_rdata;

    base = act_q.size();
    d0   = data_wr_cnt;
    t0   = tag_wr_cnt;
    r0   = ready_cnt;
    u0   = unstable_cnt;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    n = 1;
    while (!cpu_ready && n < 600) begin
      cpu_req   = (n == glitch_at);
      cpu_we    = 1'($urandom);
      cpu_addr  = AW'($urandom);
      cpu_wdata = $urandom;
      @(negedge clk);
      n++;
    end
    cpu_req = 1'b0;
    check_eq("ready_seen", cpu_ready, 1);
    if (!we && hit) check_eq("hit_latency", n, 2);
    check_eq("rdata", cpu_rdata, exp_rdata);
    @(negedge clk);
    check_eq("ready_one_cycle", cpu_ready, 0);
    check_eq("ready_pulses", ready_cnt - r0, 1);
    check_eq("mem_tx_count", act_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < act_q.size()) check_eq("mem_tx", act_q[base + i], exp_q[i]);
    check_eq("cs_data_writes", data_wr_cnt - d0, exp_dw);
    check_eq("cs_tag_writes", tag_wr_cnt - t0, exp_tw);
    if (exp_tw == 1) check_eq("tag_write_beat", tag_word, 7);
    check_eq("mem_stable", unstable_cnt - u0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base, t0, r0, n, glitch;
    logic we;
    logic [AW-1:0] a;
    rst = 1'b1; st_clear = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = '0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_cpu_ready", cpu_ready, 0);
    check_eq("rst_cpu_rdata", cpu_rdata, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_cs_we_data", cs_we_data, 0);
    check_eq("rst_cs_we_tag", cs_we_tag, 0);
    rst = 1'b0; st_clear = 1'b0;

    // Cold read miss, then a hit in the same line.
    cpu_access(1'b0, 14'h0123, '0, 0);
    cpu_access(1'b0, 14'h0125, '0, 0);
`ifdef CACHE_STATS_EN
    check_eq("hit_cnt_early", hit_cnt, 1);
    check_eq("miss_cnt_early", miss_cnt, 1);
`endif
    // Write hit updates the line and memory; write miss leaves storage alone.
    cpu_access(1'b1, 14'h0121, 32'hDEAD_BEEF, 0);
    cpu_access(1'b0, 14'h0121, '0, 0);
    cpu_access(1'b1, 14'h3F00, 32'h1357_9BDF, 0);
    cpu_access(1'b0, 14'h3F00, '0, 0);
    // Conflict on index 4 between tags 1 and 2.
    cpu_access(1'b0, 14'h0123, '0, 0);
    cpu_access(1'b0, 14'h0223, '0, 0);
    cpu_access(1'b0, 14'h0123, '0, 0);
    // Slow memory with a stray cpu_req mid-refill.
    ack_delay = 5;
    cpu_access(1'b0, 14'h0631, '0, 10);

    // Reset after beat 3 of a refill on a fresh index.
    ack_delay = 3;
    base = act_q.size(); t0 = tag_wr_cnt; r0 = ready_cnt;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0055;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (act_q.size() - base < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("abort_beats", act_q.size() - base, 4);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_eq("abort_mem_req", mem_req, 0);
    check_eq("abort_ready", ready_cnt - r0, 0);
    check_eq("abort_tag_write", tag_wr_cnt - t0, 0);
    check_eq("abort_rdata", cpu_rdata, 0);
    last_rdata = '0; ref_hits = 0; ref_misses = 0;
    cpu_access(1'b0, 14'h0055, '0, 0);

    // Randomized traffic over a small tag/index range so hits and conflicts are common.
    for (int k = 0; k < 60; k++) begin
      ack_delay = $urandom_range(0, 3);
      we        = ($urandom_range(0, 9) < 3);
      a         = {TW'($urandom_range(1, 3)), IW'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      glitch    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      cpu_access(we, a, $urandom, glitch);
    end
`ifdef CACHE_STATS_EN
    check_eq("hit_cnt", hit_cnt, ref_hits);
    check_eq("miss_cnt", miss_cnt, ref_misses);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
